// File: rtl/latency_arbiter.sv
// latency_arbiter: one programmable-latency timer time-shared round-robin among NUM requesters.
// Latency: grant one cycle after the arbitration edge; done L cycles after grant (lat==0 counts as 1).
// Backpressure: a requester is served only when the timer is free; other requests wait and are re-arbitrated.
//
// Ports:
//   clock, rst_n  rising-edge clock, synchronous active-low reset
//   req   [NUM]        request levels, sampled only when the timer is free
//   lat   [NUM*LSIZE]  packed latencies, requester i at [i*LSIZE +: LSIZE]
//   grant [NUM]        one-hot pulse, request accepted
//   done  [NUM]        one-hot pulse, latency expired
//   busy               timer owned, grant cycle through done cycle inclusive
//   owner [IDW]        index of current/last granted requester
// Optional: define LATENCY_ARBITER_ABORT_EN to add input abort and output aborted [NUM].
module latency_arbiter #(
    parameter int NUM   = 4,
    parameter int LSIZE = 10,
    parameter int IDW   = 2
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [NUM-1:0]       req,
    input  logic [NUM*LSIZE-1:0] lat,
`ifdef LATENCY_ARBITER_ABORT_EN
    input  logic                 abort,
    output logic [NUM-1:0]       aborted,
`endif
    output logic [NUM-1:0]       grant,
    output logic [NUM-1:0]       done,
    output logic                 busy,
    output logic [IDW-1:0]       owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [LSIZE-1:0] counter;
    // First index searched at the next arbitration; reset to 0 so requester 0 wins first.
    logic [IDW-1:0]   rr_next;

    logic [IDW-1:0]   owner_inc;
    logic [IDW-1:0]   arb_base;
    logic             pick_vld;
    logic [IDW-1:0]   pick_idx;
    logic [LSIZE-1:0] pick_lat;
    logic [LSIZE-1:0] load_val;
    int unsigned      pick_pos;

    assign owner_inc = (int'(owner) == NUM - 1) ? '0 : owner + IDW'(1);

    // The DONE cycle doubles as an arbitration cycle so back-to-back grants are
    // L+1 cycles apart; its search already starts past the finishing owner.
    assign arb_base = (state == DONE) ? owner_inc : rr_next;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_pos = 0;
        for (int i = 0; i < NUM; i++) begin
            pick_pos = (int'(arb_base) + i) % NUM;
            if (!pick_vld && req[pick_pos]) begin
                pick_vld = 1'b1;
                pick_idx = IDW'(pick_pos);
            end
        end
    end

    assign pick_lat = lat[pick_idx*LSIZE +: LSIZE];
    // A zero latency loads 1 so the counter never underflows.
    assign load_val = (pick_lat == '0) ? LSIZE'(1) : pick_lat;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= '0;
            rr_next <= '0;
            grant   <= '0;
            done    <= '0;
            busy    <= 1'b0;
            owner   <= '0;
`ifdef LATENCY_ARBITER_ABORT_EN
            aborted <= '0;
`endif
        end else begin
            grant <= '0;
            done  <= '0;
`ifdef LATENCY_ARBITER_ABORT_EN
            aborted <= '0;
`endif
            case (state)
                IDLE, DONE: begin
                    if (state == DONE) begin
                        rr_next <= owner_inc;
                    end
                    if (pick_vld) begin
                        owner           <= pick_idx;
                        counter         <= load_val;
                        grant[pick_idx] <= 1'b1;
                        busy            <= 1'b1;
                        state           <= COUNT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                COUNT: begin
`ifdef LATENCY_ARBITER_ABORT_EN
                    if (abort) begin
                        // Abort beats a simultaneous expiry; pointer advances as on completion.
                        aborted[owner] <= 1'b1;
                        rr_next        <= owner_inc;
                        counter        <= '0;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end else
`endif
                    if (counter == LSIZE'(1)) begin
                        done[owner] <= 1'b1;
                        counter     <= '0;
                        state       <= DONE;
                    end else begin
                        counter <= counter - LSIZE'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latency_arbiter.sv
// Directed bench for latency_arbiter: fixed vectors with hand-computed grant/done/busy/owner timing.
module tb_latency_arbiter;

    localparam int NUM   = 4;
    localparam int LSIZE = 10;
    localparam int IDW   = 2;

    logic                 clock = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM-1:0]       req   = '0;
    logic [NUM*LSIZE-1:0] lat   = '0;
    logic [NUM-1:0]       grant;
    logic [NUM-1:0]       done;
    logic                 busy;
    logic [IDW-1:0]       owner;
`ifdef LATENCY_ARBITER_ABORT_EN
    logic                 abort = 1'b0;
    logic [NUM-1:0]       aborted;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    latency_arbiter #(.NUM(NUM), .LSIZE(LSIZE), .IDW(IDW)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .req   (req),
        .lat   (lat),
`ifdef LATENCY_ARBITER_ABORT_EN
        .abort   (abort),
        .aborted (aborted),
`endif
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .owner (owner)
    );

    always #5 clock = ~clock;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lat(input int idx, input int val);
        lat[idx*LSIZE +: LSIZE] = LSIZE'(val);
    endtask

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_done",  32'(done),  32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'h0);

        // Single requester, lat0=5: grant at T, done at T+5
        set_lat(0, 5);
        req = 4'b0001;
        tick();
        check("single_grant", 32'(grant), 32'h1);
        check("single_busy_T", 32'(busy), 32'h1);
        check("single_owner", 32'(owner), 32'h0);
        req = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("single_nodone", 32'(done), 32'h0);
            check("single_busy", 32'(busy), 32'h1);
        end
        tick();
        check("single_done", 32'(done), 32'h1);
        check("single_busy_TL", 32'(busy), 32'h1);
        check("single_grant_off", 32'(grant), 32'h0);
        tick();
        check("single_after_done", 32'(done), 32'h0);
        check("single_after_busy", 32'(busy), 32'h0);
        check("single_owner_hold", 32'(owner), 32'h0);

        // Zero latency on requester 1: grant T, done T+1
        set_lat(1, 0);
        req = 4'b0010;
        tick();
        check("zero_grant", 32'(grant), 32'h2);
        check("zero_owner", 32'(owner), 32'h1);
        req = 4'b0000;
        tick();
        check("zero_done", 32'(done), 32'h2);
        check("zero_busy", 32'(busy), 32'h1);
        tick();
        check("zero_idle_busy", 32'(busy), 32'h0);
        check("zero_owner_hold", 32'(owner), 32'h1);

        // Contention from a fresh reset: order 0,1,2,3,0, grants 3 cycles apart
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NUM; i++) set_lat(i, 2);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("cont_grant", 32'(grant), 32'(1 << exp_order[g]));
            check("cont_owner", 32'(owner), 32'(exp_order[g]));
            tick();
            check("cont_mid_done", 32'(done), 32'h0);
            check("cont_mid_grant", 32'(grant), 32'h0);
            if (g == 4) req = 4'b0000;
            tick();
            check("cont_done", 32'(done), 32'(1 << exp_order[g]));
        end
        tick();
        check("cont_end_grant", 32'(grant), 32'h0);
        check("cont_end_busy", 32'(busy), 32'h0);

        // Latency change during COUNT has no effect: lat2=8 at grant, then 1
        set_lat(2, 8);
        req = 4'b0100;
        tick();
        check("latchg_grant", 32'(grant), 32'h4);
        set_lat(2, 1);
        req = 4'b0000;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("latchg_nodone", 32'(done), 32'h0);
        end
        tick();
        check("latchg_done", 32'(done), 32'h4);
        tick();

        // Reset mid-count on requester 3 (lat 10): no done, then fresh full count
        set_lat(3, 10);
        req = 4'b1000;
        tick();
        check("rstmid_grant", 32'(grant), 32'h8);
        req = 4'b0000;
        for (int k = 1; k <= 3; k++) tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("rstmid_grant0", 32'(grant), 32'h0);
        check("rstmid_done0",  32'(done),  32'h0);
        check("rstmid_busy0",  32'(busy),  32'h0);
        check("rstmid_owner0", 32'(owner), 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("rstmid_nodone", 32'(done), 32'h0);
        end
        req = 4'b1000;
        tick();
        check("rstmid_regrant", 32'(grant), 32'h8);
        check("rstmid_reowner", 32'(owner), 32'h3);
        req = 4'b0000;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("rstmid_renodone", 32'(done), 32'h0);
        end
        tick();
        check("rstmid_redone", 32'(done), 32'h8);
        tick();

`ifdef LATENCY_ARBITER_ABORT_EN
        // Abort: grant[0] lat 6, abort in T+3 -> aborted[0] at T+4, next pick is 1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_lat(0, 6);
        set_lat(1, 3);
        req = 4'b0001;
        tick();
        check("abort_grant", 32'(grant), 32'h1);
        req = 4'b0000;
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_pulse", 32'(aborted), 32'h1);
        check("abort_nodone", 32'(done), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        req = 4'b0011;
        tick();
        check("abort_next_grant", 32'(grant), 32'h2);
        req = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("abort_no_done0", 32'(done[0]), 32'h0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
